// File: rtl/multi_digit_addr_streamer_if.sv
// Config, control and address-stream bundle for multi_digit_addr_streamer.
// master = the block driving config/control and accepting beats; slave = the streamer.
interface multi_digit_addr_streamer_if #(
  parameter int DIGIT_WIDTH  = 16,
  parameter int TOTAL_DIGITS = 4,
  parameter int ADDR_WIDTH   = 24
);
  logic                                cfg_valid;
  logic                                cfg_ready;
  logic [TOTAL_DIGITS*DIGIT_WIDTH-1:0] cfg_sizes;
  logic [TOTAL_DIGITS*DIGIT_WIDTH-1:0] cfg_strides;
  logic [ADDR_WIDTH-1:0]               cfg_base;
  logic                                cfg_continuous;
  logic                                start;
  logic                                abort;
  logic                                busy;
  logic                                addr_valid;
  logic                                addr_ready;
  logic [ADDR_WIDTH-1:0]               addr;
  logic [TOTAL_DIGITS-1:0]             addr_first;
  logic [TOTAL_DIGITS-1:0]             addr_last;
  logic                                done;

  modport master (
    output cfg_valid, cfg_sizes, cfg_strides, cfg_base, cfg_continuous,
           start, abort, addr_ready,
    input  cfg_ready, busy, addr_valid, addr, addr_first, addr_last, done
  );

  modport slave (
    input  cfg_valid, cfg_sizes, cfg_strides, cfg_base, cfg_continuous,
           start, abort, addr_ready,
    output cfg_ready, busy, addr_valid, addr, addr_first, addr_last, done
  );
endinterface

// File: rtl/multi_digit_addr_streamer.sv
// N-digit nested-loop address generator streaming one address per accepted beat.
// Optional MDAS_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module multi_digit_addr_streamer #(
  parameter int DIGIT_WIDTH  = 16,
  parameter int TOTAL_DIGITS = 4,
  parameter int ADDR_WIDTH   = 24
) (
  input  logic clk,
  input  logic resetn,
  multi_digit_addr_streamer_if.slave bus
`ifdef MDAS_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state;
  logic [DIGIT_WIDTH-1:0]  r_sizes   [TOTAL_DIGITS];
  logic [DIGIT_WIDTH-1:0]  r_strides [TOTAL_DIGITS];
  logic [DIGIT_WIDTH-1:0]  r_idx     [TOTAL_DIGITS];
  logic [ADDR_WIDTH-1:0]   r_part    [TOTAL_DIGITS];
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_cont;
  logic                    r_valid;
  logic                    r_done;
  logic [TOTAL_DIGITS-1:0] r_first;
  logic [TOTAL_DIGITS-1:0] r_last;

  logic                    w_handshake;
  logic                    w_all_last;
  logic [DIGIT_WIDTH-1:0]  w_cfg_size [TOTAL_DIGITS];
  logic [DIGIT_WIDTH-1:0]  w_size_m1  [TOTAL_DIGITS];
  logic [DIGIT_WIDTH-1:0]  w_nidx     [TOTAL_DIGITS];
  logic [ADDR_WIDTH-1:0]   w_npart    [TOTAL_DIGITS];
  logic [ADDR_WIDTH-1:0]   w_naddr;
  logic [TOTAL_DIGITS-1:0] w_nfirst;
  logic [TOTAL_DIGITS-1:0] w_nlast;
  logic [TOTAL_DIGITS-1:0] w_start_last;

  assign w_handshake = r_valid & bus.addr_ready;

  // Ripple carry through the digits: a digit steps only when every faster digit sits at its last index.
  always_comb begin
    logic carry;
    carry        = 1'b1;
    w_naddr      = r_base;
    w_nfirst     = '0;
    w_nlast      = '0;
    w_start_last = '0;
    for (int i = 0; i < TOTAL_DIGITS; i++) begin
      w_cfg_size[i] = bus.cfg_sizes[i*DIGIT_WIDTH +: DIGIT_WIDTH];
      if (w_cfg_size[i] == '0) w_cfg_size[i] = DIGIT_WIDTH'(1);
      w_size_m1[i]    = (r_sizes[i] == '0) ? '0 : r_sizes[i] - DIGIT_WIDTH'(1);
      w_start_last[i] = (w_size_m1[i] == '0);
      w_nidx[i]       = r_idx[i];
      w_npart[i]      = r_part[i];
      if (carry) begin
        if (r_idx[i] == w_size_m1[i]) begin
          w_nidx[i]  = '0;
          w_npart[i] = '0;
        end else begin
          w_nidx[i]  = r_idx[i] + DIGIT_WIDTH'(1);
          w_npart[i] = r_part[i] + ADDR_WIDTH'(r_strides[i]);
        end
      end
      carry       = carry & (r_idx[i] == w_size_m1[i]);
      w_nfirst[i] = (w_nidx[i] == '0);
      w_nlast[i]  = (w_nidx[i] == w_size_m1[i]);
      w_naddr     = w_naddr + w_npart[i];
    end
    w_all_last = carry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_cont  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_first <= '0;
      r_last  <= '0;
      for (int i = 0; i < TOTAL_DIGITS; i++) begin
        r_sizes[i]   <= '0;
        r_strides[i] <= '0;
        r_idx[i]     <= '0;
        r_part[i]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (bus.cfg_valid && r_state == S_IDLE) begin
        r_base <= bus.cfg_base;
        r_cont <= bus.cfg_continuous;
        for (int i = 0; i < TOTAL_DIGITS; i++) begin
          r_sizes[i]   <= w_cfg_size[i];
          r_strides[i] <= bus.cfg_strides[i*DIGIT_WIDTH +: DIGIT_WIDTH];
        end
      end
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        for (int i = 0; i < TOTAL_DIGITS; i++) begin
          r_idx[i]  <= '0;
          r_part[i] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
              r_addr  <= r_base;
              r_first <= '1;
              r_last  <= w_start_last;
              for (int i = 0; i < TOTAL_DIGITS; i++) begin
                r_idx[i]  <= '0;
                r_part[i] <= '0;
              end
            end
          end
          S_RUN: begin
            if (w_handshake) begin
              // A wrapping final beat already yields zero indices/partials, so both branches reuse them.
              for (int i = 0; i < TOTAL_DIGITS; i++) begin
                r_idx[i]  <= w_nidx[i];
                r_part[i] <= w_npart[i];
              end
              if (w_all_last && !r_cont) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_addr  <= w_naddr;
                r_first <= w_nfirst;
                r_last  <= w_nlast;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef MDAS_STALL_COUNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
    end else if (r_state == S_IDLE && bus.start && !bus.abort) begin
      r_stall_cycles <= '0;
    end else if (r_valid && !bus.addr_ready && r_stall_cycles != '1) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign bus.cfg_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state == S_RUN);
  assign bus.addr_valid = r_valid;
  assign bus.addr       = r_addr;
  assign bus.addr_first = r_first;
  assign bus.addr_last  = r_last;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_multi_digit_addr_streamer.sv
// Directed bench for multi_digit_addr_streamer: a vector table for one-shot/backpressure runs,
// then hand-written sequences for continuous mode, abort, zero sizes, config/start overlap and 8-bit wrap.
module tb_multi_digit_addr_streamer;
  localparam int DW = 16;
  localparam int TD = 4;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  multi_digit_addr_streamer_if #(.DIGIT_WIDTH(DW), .TOTAL_DIGITS(TD), .ADDR_WIDTH(AW)) bus ();
  multi_digit_addr_streamer_if #(.DIGIT_WIDTH(DW), .TOTAL_DIGITS(TD), .ADDR_WIDTH(8))  bus8 ();

`ifdef MDAS_STALL_COUNT_EN
  logic [31:0] stallCycles;
  logic [31:0] stallCycles8;
`endif

  multi_digit_addr_streamer #(.DIGIT_WIDTH(DW), .TOTAL_DIGITS(TD), .ADDR_WIDTH(AW)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef MDAS_STALL_COUNT_EN
    ,
    .stall_cycles (stallCycles)
`endif
  );

  multi_digit_addr_streamer #(.DIGIT_WIDTH(DW), .TOTAL_DIGITS(TD), .ADDR_WIDTH(8)) u_dut8 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus8)
`ifdef MDAS_STALL_COUNT_EN
    ,
    .stall_cycles (stallCycles8)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        expValid;
    logic [23:0] expAddr;
    logic [3:0]  expFirst;
    logic [3:0]  expLast;
    logic        expDone;
    logic        expBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic s, input logic r, input logic v, input logic [23:0] a,
                        input logic [3:0] f, input logic [3:0] l, input logic d, input logic b);
    vec_t row;
    row.start = s; row.ready = r; row.expValid = v; row.expAddr = a;
    row.expFirst = f; row.expLast = l; row.expDone = d; row.expBusy = b;
    vecs.push_back(row);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic a);
    bus.start      = s;
    bus.addr_ready = r;
    bus.abort      = a;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setConfig(input logic [63:0] sizes, input logic [63:0] strides,
                           input logic [23:0] base, input logic cont);
    bus.cfg_sizes      = sizes;
    bus.cfg_strides    = strides;
    bus.cfg_base       = base;
    bus.cfg_continuous = cont;
    bus.cfg_valid      = 1'b1;
    cycle();
    bus.cfg_valid      = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input logic [23:0] a, input logic [3:0] f, input logic [3:0] l);
    checkOutput({tag, " valid"}, 32'(bus.addr_valid), 32'd1);
    checkOutput({tag, " addr"}, 32'(bus.addr), 32'(a));
    checkOutput({tag, " first"}, 32'(bus.addr_first), 32'(f));
    checkOutput({tag, " last"}, 32'(bus.addr_last), 32'(l));
  endtask

  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, " valid"}, 32'(bus.addr_valid), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " done"}, 32'(bus.done), 32'(expDone));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [23:0] contPat [4];
    logic [23:0] passAddr [6];
    logic [7:0]  e8;
    vec_t        v;
    int          expStall;

    contPat  = '{24'd0, 24'd1, 24'd4, 24'd5};
    passAddr = '{24'd100, 24'd101, 24'd102, 24'd110, 24'd111, 24'd112};

    // One-shot pass with ready held high, then the same pass under a 1-0-0-1 ready pattern.
    addRow(1, 1, 0, 0,   4'b0000, 4'b0000, 0, 0);
    addRow(0, 1, 1, 100, 4'b1111, 4'b1100, 0, 1);
    addRow(0, 1, 1, 101, 4'b1110, 4'b1100, 0, 1);
    addRow(0, 1, 1, 102, 4'b1110, 4'b1101, 0, 1);
    addRow(0, 1, 1, 110, 4'b1101, 4'b1110, 0, 1);
    addRow(0, 1, 1, 111, 4'b1100, 4'b1110, 0, 1);
    addRow(0, 1, 1, 112, 4'b1100, 4'b1111, 0, 1);
    addRow(0, 1, 0, 0,   4'b0000, 4'b0000, 1, 0);
    addRow(1, 1, 0, 0,   4'b0000, 4'b0000, 0, 0);
    addRow(0, 1, 1, 100, 4'b1111, 4'b1100, 0, 1);
    addRow(0, 0, 1, 101, 4'b1110, 4'b1100, 0, 1);
    addRow(1, 0, 1, 101, 4'b1110, 4'b1100, 0, 1);
    addRow(0, 1, 1, 101, 4'b1110, 4'b1100, 0, 1);
    addRow(0, 1, 1, 102, 4'b1110, 4'b1101, 0, 1);
    addRow(0, 0, 1, 110, 4'b1101, 4'b1110, 0, 1);
    addRow(0, 0, 1, 110, 4'b1101, 4'b1110, 0, 1);
    addRow(0, 1, 1, 110, 4'b1101, 4'b1110, 0, 1);
    addRow(0, 1, 1, 111, 4'b1100, 4'b1110, 0, 1);
    addRow(0, 0, 1, 112, 4'b1100, 4'b1111, 0, 1);
    addRow(0, 0, 1, 112, 4'b1100, 4'b1111, 0, 1);
    addRow(0, 1, 1, 112, 4'b1100, 4'b1111, 0, 1);
    addRow(0, 1, 0, 0,   4'b0000, 4'b0000, 1, 0);
    addRow(0, 1, 0, 0,   4'b0000, 4'b0000, 0, 0);

    bus.cfg_valid = 0; bus.cfg_sizes = '0; bus.cfg_strides = '0; bus.cfg_base = '0;
    bus.cfg_continuous = 0; bus.start = 0; bus.abort = 0; bus.addr_ready = 0;
    bus8.cfg_valid = 0; bus8.cfg_sizes = '0; bus8.cfg_strides = '0; bus8.cfg_base = '0;
    bus8.cfg_continuous = 0; bus8.start = 0; bus8.abort = 0; bus8.addr_ready = 0;

    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    cycle();
    checkOutput("reset cfg_ready", 32'(bus.cfg_ready), 32'd1);
    checkIdle("reset", 1'b0);
    checkOutput("reset addr", 32'(bus.addr), 32'd0);
    checkOutput("reset first", 32'(bus.addr_first), 32'd0);
    checkOutput("reset last", 32'(bus.addr_last), 32'd0);

    setConfig({16'd1, 16'd1, 16'd2, 16'd3}, {16'd0, 16'd0, 16'd10, 16'd1}, 24'd100, 1'b0);
    expStall = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      checkOutput($sformatf("row%0d valid", i), 32'(bus.addr_valid), 32'(v.expValid));
      checkOutput($sformatf("row%0d done", i), 32'(bus.done), 32'(v.expDone));
      checkOutput($sformatf("row%0d busy", i), 32'(bus.busy), 32'(v.expBusy));
      checkOutput($sformatf("row%0d cfg_ready", i), 32'(bus.cfg_ready), 32'(!v.expBusy));
      if (v.expValid) begin
        checkOutput($sformatf("row%0d addr", i), 32'(bus.addr), 32'(v.expAddr));
        checkOutput($sformatf("row%0d first", i), 32'(bus.addr_first), 32'(v.expFirst));
        checkOutput($sformatf("row%0d last", i), 32'(bus.addr_last), 32'(v.expLast));
      end
      if (v.start && !v.expBusy) expStall = 0;
      else if (v.expValid && !v.ready) expStall++;
      applyStimulus(v.start, v.ready, 1'b0);
      cycle();
    end
`ifdef MDAS_STALL_COUNT_EN
    checkOutput("stall_cycles", stallCycles, 32'(expStall));
`endif

    // Continuous 2x2 nest keeps wrapping to base without done.
    setConfig({16'd1, 16'd1, 16'd2, 16'd2}, {16'd0, 16'd0, 16'd4, 16'd1}, 24'd0, 1'b1);
    applyStimulus(1, 1, 0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("cont%0d valid", k), 32'(bus.addr_valid), 32'd1);
      checkOutput($sformatf("cont%0d addr", k), 32'(bus.addr), 32'(contPat[k % 4]));
      checkOutput($sformatf("cont%0d busy", k), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("cont%0d done", k), 32'(bus.done), 32'd0);
      applyStimulus(0, 1, 0);
      cycle();
    end
    applyStimulus(0, 1, 1);
    cycle();
    checkIdle("cont abort", 1'b0);

    // Abort on the stalled third beat, then a fresh start replays the whole pass.
    setConfig({16'd1, 16'd1, 16'd2, 16'd3}, {16'd0, 16'd0, 16'd10, 16'd1}, 24'd100, 1'b0);
    applyStimulus(1, 1, 0);
    cycle();
    checkBeat("ab beat0", 24'd100, 4'b1111, 4'b1100);
    applyStimulus(0, 1, 0);
    cycle();
    checkBeat("ab beat1", 24'd101, 4'b1110, 4'b1100);
    cycle();
    checkBeat("ab beat2", 24'd102, 4'b1110, 4'b1101);
    applyStimulus(0, 0, 1);
    cycle();
    checkIdle("ab after", 1'b0);
    applyStimulus(0, 0, 0);
    cycle();
    checkIdle("ab settle", 1'b0);
    applyStimulus(1, 1, 0);
    cycle();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rerun%0d valid", i), 32'(bus.addr_valid), 32'd1);
      checkOutput($sformatf("rerun%0d addr", i), 32'(bus.addr), 32'(passAddr[i]));
      applyStimulus(0, 1, 0);
      cycle();
    end
    checkIdle("rerun end", 1'b1);

    // Config and start together: the beat uses the old base; the new all-zero sizes give one beat.
    bus.cfg_sizes = '0; bus.cfg_strides = '0; bus.cfg_base = 24'd7; bus.cfg_continuous = 0;
    bus.cfg_valid = 1;
    applyStimulus(1, 0, 0);
    cycle();
    bus.cfg_valid = 0;
    checkOutput("overlap addr", 32'(bus.addr), 32'd100);
    checkOutput("overlap cfg_ready", 32'(bus.cfg_ready), 32'd0);
    applyStimulus(0, 0, 1);
    cycle();
    checkIdle("overlap abort", 1'b0);
    applyStimulus(1, 1, 0);
    cycle();
    checkBeat("zero sizes", 24'd7, 4'b1111, 4'b1111);
    applyStimulus(0, 1, 0);
    cycle();
    checkIdle("zero sizes end", 1'b1);

    // 8-bit address instance wraps modulo 256.
    bus8.cfg_sizes = {16'd0, 16'd0, 16'd0, 16'd10};
    bus8.cfg_strides = {16'd0, 16'd0, 16'd0, 16'd1};
    bus8.cfg_base = 8'd250;
    bus8.cfg_valid = 1;
    cycle();
    bus8.cfg_valid = 0;
    bus8.start = 1;
    bus8.addr_ready = 1;
    cycle();
    bus8.start = 0;
    for (int i = 0; i < 10; i++) begin
      e8 = 8'd250 + 8'(i);
      checkOutput($sformatf("w8 beat%0d valid", i), 32'(bus8.addr_valid), 32'd1);
      checkOutput($sformatf("w8 beat%0d addr", i), 32'(bus8.addr), 32'(e8));
      checkOutput($sformatf("w8 beat%0d cfg_ready", i), 32'(bus8.cfg_ready), 32'd0);
      checkOutput($sformatf("w8 beat%0d first0", i), 32'(bus8.addr_first[0]), 32'(i == 0));
      checkOutput($sformatf("w8 beat%0d last0", i), 32'(bus8.addr_last[0]), 32'(i == 9));
      cycle();
    end
    checkOutput("w8 done", 32'(bus8.done), 32'd1);
    checkOutput("w8 cfg_ready", 32'(bus8.cfg_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
